// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Contents: scan FSM state encoding and the all-anodes-off helper constant.
package seg_scan_pkg;

   // Scan FSM: blanking gap, then one digit driven
   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_e;

   // All anodes off (active-low); slice to the digit count at the use site
   localparam int unsigned AN_MAX_W = 32;
   localparam logic [AN_MAX_W-1:0] AN_OFF = '1;

endpackage

// File: rtl/seg_scan_lzmask.sv
// Leading-zero blank mask for seg_scan.
// Ports:
//   active     in  4*N_DIGITS  displayed hex value
//   blank_mask out N_DIGITS    bit i set when digit i>0 and every nibble from i upward is zero
// Exists only in builds with SEG_SCAN_LZ_BLANK_EN defined.
`ifdef SEG_SCAN_LZ_BLANK_EN
module seg_scan_lzmask #(
   parameter int unsigned N_DIGITS = 4
) (
   input  logic [4*N_DIGITS-1:0] active,
   output logic [N_DIGITS-1:0]   blank_mask
);

   // Digit 0 is never blanked, so the loop starts at 1
   always_comb begin
      blank_mask = '0;
      for (int unsigned i = 1; i < N_DIGITS; i++) begin
         blank_mask[i] = ((active >> (4 * i)) == '0);
      end
   end

endmodule
`endif

// File: rtl/seg_scan.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   value       packed hex digits, digit 0 rightmost
//   load        strobe: capture value into the pending buffer
//   digit       nibble of the scanned digit (to sev_decoder.x)
//   an          active-low anode enables, at most one low
//   pending     a loaded value awaits the next frame boundary
//   frame_done  one-cycle pulse at each frame boundary
// Optional: SEG_SCAN_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan #(
   parameter int unsigned N_DIGITS  = 4,
   parameter int unsigned DIV       = 50000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic                  load,
   output logic [3:0]            digit,
   output logic [N_DIGITS-1:0]   an,
   output logic                  pending,
   output logic                  frame_done
);
   import seg_scan_pkg::*;

   localparam int unsigned VAL_W   = 4 * N_DIGITS;
   localparam int unsigned CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [VAL_W-1:0]    pend_q, pend_d;
   logic [VAL_W-1:0]    active_q, active_d;
   logic                pending_q, pending_d;
   logic                frame_done_q, frame_done_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic [3:0]          digit_q, digit_d;
   logic [N_DIGITS-1:0] lz_mask;
   logic [N_DIGITS-1:0] sel;

`ifdef SEG_SCAN_LZ_BLANK_EN
   seg_scan_lzmask #(.N_DIGITS(N_DIGITS)) u_lzmask (
      .active     (active_q),
      .blank_mask (lz_mask)
   );
`else
   assign lz_mask = '0;
`endif

   // One-hot select of the current digit
   assign sel = N_DIGITS'(1) << idx_q;

   // Next-state, buffer commit and output computation
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      pend_d       = pend_q;
      active_d     = active_q;
      pending_d    = pending_q;
      frame_done_d = 1'b0;
      an_d         = AN_OFF[N_DIGITS-1:0];
      digit_d      = digit_q;

      case (state_q)
         S_BLANK: begin
            if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
               state_d = S_DRIVE;
               cnt_d   = '0;
            end
         end
         S_DRIVE: begin
            if (cnt_q == CNT_W'(DIV - 1)) begin
               state_d = S_BLANK;
               cnt_d   = '0;
               if (idx_q == IDX_W'(N_DIGITS - 1)) begin
                  idx_d        = '0;
                  frame_done_d = 1'b1;
                  if (pending_q) begin
                     active_d  = pend_q;
                     pending_d = 1'b0;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
      endcase

      // A load on the commit edge wins: the old pend commits, the new one waits
      if (load) begin
         pend_d    = value;
         pending_d = 1'b1;
      end

      // Outputs follow the next state; idx/active only change on leaving S_DRIVE
      if (state_d == S_DRIVE) begin
         digit_d = 4'(active_q >> {idx_q, 2'b00});
         an_d    = ~(sel & ~lz_mask);
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_BLANK;
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_q       <= '0;
         active_q     <= '0;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
         an_q         <= AN_OFF[N_DIGITS-1:0];
         digit_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         frame_done_q <= frame_done_d;
         an_q         <= an_d;
         digit_q      <= digit_d;
      end
   end

   assign digit      = digit_q;
   assign an         = an_q;
   assign pending    = pending_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan (N_DIGITS=4, DIV=4, BLANK_CYC=2).
// Reference model: display position derived from the cycle count since reset,
// double buffer updated at every multiple of the frame length.
module tb_seg_scan;

   localparam int N     = 4;
   localparam int DIV   = 4;
   localparam int BLANK = 2;
   localparam int SLOT  = BLANK + DIV;
   localparam int FRAME = N * SLOT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = '0;
   logic        load = 1'b0;
   logic [3:0]  digit;
   logic [3:0]  an;
   logic        pending;
   logic        frame_done;

   seg_scan #(.N_DIGITS(N), .DIV(DIV), .BLANK_CYC(BLANK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .load       (load),
      .digit      (digit),
      .an         (an),
      .pending    (pending),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: edges since reset release and expected outputs
   int          t;
   logic [15:0] m_pend, m_active;
   logic        m_pending, m_fd;
   logic [3:0]  m_digit, m_an;

   task automatic model_reset();
      t = 0;
      m_pend = '0; m_active = '0; m_pending = 1'b0; m_fd = 1'b0;
      m_digit = '0; m_an = 4'hF;
   endtask

   // Drive one cycle of stimulus and advance the model past the clock edge
   task automatic step(input logic ld, input logic [15:0] v);
      int slot, off;
      logic [15:0] hi;
      value = v;
      load  = ld;
      @(posedge clk);
      t++;
      m_fd = (t % FRAME == 0);
      if (m_fd && m_pending) begin
         m_active  = m_pend;
         m_pending = 1'b0;
      end
      if (ld) begin
         m_pend    = v;
         m_pending = 1'b1;
      end
      slot = (t / SLOT) % N;
      off  = t % SLOT;
      m_an = 4'hF;
      if (off >= BLANK) begin
         hi      = m_active >> (4 * slot);
         m_digit = hi[3:0];
`ifdef SEG_SCAN_LZ_BLANK_EN
         if (slot == 0 || hi != 16'h0) m_an = ~(4'b0001 << slot);
`else
         m_an = ~(4'b0001 << slot);
`endif
      end
      #1;
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if (an !== 4'hF)      begin errors++; $display("FAIL reset_an got %b want 1111", an); end
      checks++;
      if (digit !== 4'h0)   begin errors++; $display("FAIL reset_digit got %h want 0", digit); end
      checks++;
      if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
      checks++;
      if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
      checks++;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_first_load();
      for (int c = 0; c < 2 * FRAME + 2; c++) begin
         step(c == 0, (c == 0) ? 16'h1234 : 16'(($urandom)));
         if (an !== m_an || digit !== m_digit || pending !== m_pending || frame_done !== m_fd) begin
            errors++;
            $display("FAIL first_load t=%0d an=%b/%b digit=%h/%h pend=%b/%b fd=%b/%b",
                     t, an, m_an, digit, m_digit, pending, m_pending, frame_done, m_fd);
         end
         checks++;
      end
   endtask

   task automatic test_load_mid();
      bit loaded = 0;
      for (int c = 0; c < 3 * FRAME; c++) begin
         bit ld = !loaded && (t % FRAME == 14);
         if (ld) loaded = 1;
         step(ld, ld ? 16'hABCD : 16'(($urandom)));
         if (an !== m_an || digit !== m_digit || pending !== m_pending || frame_done !== m_fd) begin
            errors++;
            $display("FAIL load_mid t=%0d an=%b/%b digit=%h/%h pend=%b/%b fd=%b/%b",
                     t, an, m_an, digit, m_digit, pending, m_pending, frame_done, m_fd);
         end
         checks++;
         if (loaded && frame_done === 1'b1) begin
            if (pending !== 1'b0) begin errors++; $display("FAIL load_mid_commit pending got %b want 0", pending); end
            checks++;
            loaded = 0;
            c = 2 * FRAME;
         end
      end
   endtask

   task automatic test_two_loads();
      for (int c = 0; c < 3 * FRAME; c++) begin
         bit ld1 = (c == 3);
         bit ld2 = (c == 9);
         step(ld1 || ld2, ld1 ? 16'h1111 : (ld2 ? 16'h2222 : 16'(($urandom))));
         if (an !== m_an || digit !== m_digit || pending !== m_pending || frame_done !== m_fd) begin
            errors++;
            $display("FAIL two_loads t=%0d an=%b/%b digit=%h/%h pend=%b/%b fd=%b/%b",
                     t, an, m_an, digit, m_digit, pending, m_pending, frame_done, m_fd);
         end
         checks++;
      end
   endtask

   task automatic test_load_on_boundary();
      step(1'b1, 16'h9999);
      while (t % FRAME != FRAME - 1) step(1'b0, 16'(($urandom)));
      step(1'b1, 16'h5555);
      if (frame_done !== 1'b1) begin errors++; $display("FAIL boundary_fd got %b want 1", frame_done); end
      checks++;
      if (pending !== 1'b1) begin errors++; $display("FAIL boundary_pending got %b want 1", pending); end
      checks++;
      for (int c = 0; c < 2 * FRAME + 1; c++) begin
         step(1'b0, 16'(($urandom)));
         if (an !== m_an || digit !== m_digit || pending !== m_pending || frame_done !== m_fd) begin
            errors++;
            $display("FAIL boundary t=%0d an=%b/%b digit=%h/%h pend=%b/%b fd=%b/%b",
                     t, an, m_an, digit, m_digit, pending, m_pending, frame_done, m_fd);
         end
         checks++;
      end
   endtask

   task automatic test_lz();
      for (int c = 0; c < 4 * FRAME; c++) begin
         bit ld1 = (c == 0);
         bit ld2 = (c == 2 * FRAME);
         step(ld1 || ld2, ld1 ? 16'h0050 : (ld2 ? 16'h0000 : 16'(($urandom))));
         if (an !== m_an || digit !== m_digit || pending !== m_pending || frame_done !== m_fd) begin
            errors++;
            $display("FAIL lz t=%0d an=%b/%b digit=%h/%h pend=%b/%b fd=%b/%b",
                     t, an, m_an, digit, m_digit, pending, m_pending, frame_done, m_fd);
         end
         checks++;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 6 * FRAME; c++) begin
         bit ld = ($urandom_range(0, 9) == 0);
         step(ld, 16'(($urandom)));
         if (an !== m_an || digit !== m_digit || pending !== m_pending || frame_done !== m_fd) begin
            errors++;
            $display("FAIL random t=%0d an=%b/%b digit=%h/%h pend=%b/%b fd=%b/%b",
                     t, an, m_an, digit, m_digit, pending, m_pending, frame_done, m_fd);
         end
         checks++;
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 16'hFEDC);
      while (t % FRAME != 0) step(1'b0, 16'(($urandom)));
      while (t % FRAME != 15) step(1'b0, 16'(($urandom)));
      if (an !== 4'b1011) begin errors++; $display("FAIL reset_mid_pre an got %b want 1011", an); end
      checks++;
      #2 rst_n = 1'b0;
      #1;
      if (an !== 4'hF)    begin errors++; $display("FAIL reset_mid_an got %b want 1111", an); end
      checks++;
      if (digit !== 4'h0) begin errors++; $display("FAIL reset_mid_digit got %h want 0", digit); end
      checks++;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < FRAME + 2; c++) begin
         step(1'b0, 16'(($urandom)));
         if (an !== m_an || digit !== m_digit || pending !== m_pending || frame_done !== m_fd) begin
            errors++;
            $display("FAIL reset_mid t=%0d an=%b/%b digit=%h/%h pend=%b/%b fd=%b/%b",
                     t, an, m_an, digit, m_digit, pending, m_pending, frame_done, m_fd);
         end
         checks++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_first_load();
      test_load_mid();
      test_two_loads();
      test_load_on_boundary();
      test_lz();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
